// File: rtl/tod_regs_pkg.sv
// Shared definitions for the ToD CPU-interface register block:
// register offsets, CTRL bit positions, ns-per-second limit and access FSM states.
package tod_regs_pkg;

  localparam logic [7:0] OFF_ID          = 8'h00;
  localparam logic [7:0] OFF_CTRL        = 8'h04;
  localparam logic [7:0] OFF_INCR        = 8'h08;
  localparam logic [7:0] OFF_NS_LOAD     = 8'h0C;
  localparam logic [7:0] OFF_SEC_LOAD_LO = 8'h10;
  localparam logic [7:0] OFF_SEC_LOAD_HI = 8'h14;
  localparam logic [7:0] OFF_NS_SNAP     = 8'h18;
  localparam logic [7:0] OFF_SEC_SNAP_LO = 8'h1C;
  localparam logic [7:0] OFF_SEC_SNAP_HI = 8'h20;
  localparam logic [7:0] OFF_SCRATCH     = 8'h24;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_SNAPSHOT = 1;
  localparam int CTRL_LOAD     = 2;

  localparam logic [29:0] NS_PER_SEC = 30'd1_000_000_000;
  localparam logic [29:0] NS_MAX     = NS_PER_SEC - 30'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/tod_cpu_if_regs_if.sv
// CPU-interface request/response bundle between the CDC bridge (master)
// and the ToD register block (slave).
interface tod_cpu_if_regs_if;
  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic [31:2] address;
  logic [31:0] read_data;
  logic        access_complete;

  modport master (
    output read, write, write_data, address,
    input  read_data, access_complete
  );

  modport slave (
    input  read, write, write_data, address,
    output read_data, access_complete
  );
endinterface

// File: rtl/tod_counter.sv
// Free-running PTP time-of-day counter (30-bit ns, 48-bit sec) with
// load, atomic snapshot and a one-cycle pps on each seconds rollover.
module tod_counter
  import tod_regs_pkg::*;
(
  input  logic        h_clk,
  input  logic        h_reset_n,
  input  logic        enable,
  input  logic        load,
  input  logic        snapshot,
  input  logic [7:0]  incr,
  input  logic [29:0] ns_load,
  input  logic [47:0] sec_load,
  output logic [29:0] tod_ns,
  output logic [47:0] tod_sec,
  output logic        pps,
  output logic [29:0] snap_ns,
  output logic [47:0] snap_sec
);

  // ns never exceeds 999_999_999, so ns + 255 always fits in 30 bits
  logic [29:0] ns_sum;
  logic [29:0] ns_wrap;
  logic        rollover;

  function automatic logic [29:0] clamp_ns(input logic [29:0] v);
    return (v >= NS_PER_SEC) ? NS_MAX : v;
  endfunction

  assign ns_sum   = tod_ns + {22'd0, incr};
  assign ns_wrap  = ns_sum - NS_PER_SEC;
  assign rollover = (ns_sum >= NS_PER_SEC);

  always_ff @(posedge h_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      tod_ns   <= '0;
      tod_sec  <= '0;
      pps      <= 1'b0;
      snap_ns  <= '0;
      snap_sec <= '0;
    end else begin
      pps <= 1'b0;
      if (load) begin
        tod_ns  <= clamp_ns(ns_load);
        tod_sec <= sec_load;
      end else if (enable) begin
        if (rollover) begin
          tod_ns  <= ns_wrap;
          tod_sec <= tod_sec + 48'd1;
          pps     <= 1'b1;
        end else begin
          tod_ns <= ns_sum;
        end
      end
      // snapshot sees the count as it was before this edge
      if (snapshot) begin
        snap_ns  <= tod_ns;
        snap_sec <= tod_sec;
      end
    end
  end

endmodule

// File: rtl/tod_cpu_if_regs.sv
// CPU-interface responder for the ToD block: fixed-latency access FSM,
// control/status register file and the ToD counter instance.
module tod_cpu_if_regs
  import tod_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned ACCESS_LATENCY = 2,
  parameter logic [7:0]  NS_PER_CLK     = 8'd8,
  parameter logic [31:0] ID_VALUE       = 32'h7D0D_0001
) (
  input  logic               h_clk,
  input  logic               h_reset_n,
  tod_cpu_if_regs_if.slave   h_cpu_if,
  output logic [29:0]        tod_ns,
  output logic [47:0]        tod_sec,
  output logic               pps
);

  localparam logic [3:0] WAIT_LOAD = 4'(ACCESS_LATENCY - 2);

  acc_state_t  state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        rd_q, hit_q;
  logic [7:0]  off_q;

  logic        idle, req, req_rd, req_wr, hit;
  logic [7:0]  off;
  logic        cur_rd, cur_hit;
  logic [7:0]  cur_off;
  logic        wr_en, load_pulse, snap_pulse;
  logic [31:0] rd_mux;

  logic        ctrl_enable;
  logic [7:0]  incr;
  logic [29:0] ns_load;
  logic [31:0] sec_load_lo;
  logic [15:0] sec_load_hi;
  logic [31:0] scratch;
  logic [29:0] snap_ns;
  logic [47:0] snap_sec;

  // a simultaneous read+write is taken as a write
  assign idle   = (state == IDLE);
  assign req    = idle && (h_cpu_if.read || h_cpu_if.write);
  assign req_wr = idle && h_cpu_if.write;
  assign req_rd = idle && h_cpu_if.read && !h_cpu_if.write;
  assign hit    = (h_cpu_if.address[31:8] == BASE_ADDR[31:8]);
  assign off    = {h_cpu_if.address[7:2], 2'b00};

  assign wr_en      = req_wr && hit;
  assign load_pulse = wr_en && (off == OFF_CTRL) && h_cpu_if.write_data[CTRL_LOAD];
  assign snap_pulse = wr_en && (off == OFF_CTRL) && h_cpu_if.write_data[CTRL_SNAPSHOT];

  // with latency 1 the read is decoded straight from the request inputs
  assign cur_rd  = idle ? req_rd : rd_q;
  assign cur_hit = idle ? hit    : hit_q;
  assign cur_off = idle ? off    : off_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (ACCESS_LATENCY <= 1) begin
            state_nx = DONE;
          end else begin
            state_nx = WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = DONE;
        else             cnt_nx   = cnt - 4'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge h_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      rd_q  <= 1'b0;
      hit_q <= 1'b0;
      off_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (req) begin
        rd_q  <= req_rd;
        hit_q <= hit;
        off_q <= off;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (cur_hit) begin
      case (cur_off)
        OFF_ID:          rd_mux = ID_VALUE;
        OFF_CTRL:        rd_mux = {31'd0, ctrl_enable};
        OFF_INCR:        rd_mux = {24'd0, incr};
        OFF_NS_LOAD:     rd_mux = {2'd0, ns_load};
        OFF_SEC_LOAD_LO: rd_mux = sec_load_lo;
        OFF_SEC_LOAD_HI: rd_mux = {16'd0, sec_load_hi};
        OFF_NS_SNAP:     rd_mux = {2'd0, snap_ns};
        OFF_SEC_SNAP_LO: rd_mux = snap_sec[31:0];
        OFF_SEC_SNAP_HI: rd_mux = {16'd0, snap_sec[47:32]};
        OFF_SCRATCH:     rd_mux = scratch;
        default:         rd_mux = '0;
      endcase
    end
  end

  // read data is captured on DONE entry and held until the next read completes
  always_ff @(posedge h_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      h_cpu_if.read_data       <= '0;
      h_cpu_if.access_complete <= 1'b0;
    end else begin
      h_cpu_if.access_complete <= (state_nx == DONE);
      if ((state_nx == DONE) && (state != DONE) && cur_rd) begin
        h_cpu_if.read_data <= rd_mux;
      end
    end
  end

  always_ff @(posedge h_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      ctrl_enable <= 1'b0;
      incr        <= NS_PER_CLK;
      ns_load     <= '0;
      sec_load_lo <= '0;
      sec_load_hi <= '0;
      scratch     <= '0;
    end else if (wr_en) begin
      case (off)
        OFF_CTRL:        ctrl_enable <= h_cpu_if.write_data[CTRL_ENABLE];
        OFF_INCR:        incr        <= h_cpu_if.write_data[7:0];
        OFF_NS_LOAD:     ns_load     <= h_cpu_if.write_data[29:0];
        OFF_SEC_LOAD_LO: sec_load_lo <= h_cpu_if.write_data;
        OFF_SEC_LOAD_HI: sec_load_hi <= h_cpu_if.write_data[15:0];
        OFF_SCRATCH:     scratch     <= h_cpu_if.write_data;
        default:         ;
      endcase
    end
  end

  tod_counter u_tod_counter (
    .h_clk     (h_clk),
    .h_reset_n (h_reset_n),
    .enable    (ctrl_enable),
    .load      (load_pulse),
    .snapshot  (snap_pulse),
    .incr      (incr),
    .ns_load   (ns_load),
    .sec_load  ({sec_load_hi, sec_load_lo}),
    .tod_ns    (tod_ns),
    .tod_sec   (tod_sec),
    .pps       (pps),
    .snap_ns   (snap_ns),
    .snap_sec  (snap_sec)
  );

endmodule

// File: tb/tb_tod_cpu_if_regs.sv
// Directed bench for tod_cpu_if_regs: register access, latency, address decode,
// ToD load/rollover/pps, snapshot, clamp, read+write collision and mid-access reset.
module tb_tod_cpu_if_regs;
  import tod_regs_pkg::*;

  logic        h_clk = 1'b0;
  logic        h_reset_n = 1'b0;
  logic [29:0] tod_ns;
  logic [47:0] tod_sec;
  logic        pps;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] rdata;

  always #5 h_clk = ~h_clk;

  tod_cpu_if_regs_if h_cpu_if ();

  tod_cpu_if_regs #(
    .BASE_ADDR      (32'h0000_0000),
    .ACCESS_LATENCY (2),
    .NS_PER_CLK     (8'd8),
    .ID_VALUE       (32'h7D0D_0001)
  ) dut (
    .h_clk     (h_clk),
    .h_reset_n (h_reset_n),
    .h_cpu_if  (h_cpu_if),
    .tod_ns    (tod_ns),
    .tod_sec   (tod_sec),
    .pps       (pps)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge h_clk);
    #1;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    h_cpu_if.read       = rd;
    h_cpu_if.write      = wr;
    h_cpu_if.address    = a[31:2];
    h_cpu_if.write_data = wd;
  endtask

  task automatic clr_req();
    h_cpu_if.read  = 1'b0;
    h_cpu_if.write = 1'b0;
  endtask

  // issue one request, measure latency to complete, check the pulse is one cycle wide
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd_out);
    int lat;
    set_req(rd, wr, a, wd);
    tick();
    clr_req();
    lat = 1;
    while (h_cpu_if.access_complete !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    rd_out = h_cpu_if.read_data;
    chk({tag, "_lat"}, 64'(lat), 64'd2);
    tick();
    chk({tag, "_pulse_end"}, 64'(h_cpu_if.access_complete), 64'd0);
  endtask

  task automatic wr_reg(input string tag, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    access(tag, 1'b0, 1'b1, a, wd, dummy);
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] a, output logic [31:0] d);
    access(tag, 1'b1, 1'b0, a, 32'd0, d);
  endtask

  initial begin
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) tick();
    chk("rst_read_data", 64'(h_cpu_if.read_data), 64'd0);
    chk("rst_complete", 64'(h_cpu_if.access_complete), 64'd0);
    chk("rst_pps", 64'(pps), 64'd0);
    chk("rst_tod_ns", 64'(tod_ns), 64'd0);
    chk("rst_tod_sec", 64'(tod_sec), 64'd0);
    h_reset_n = 1'b1;
    tick();

    rd_reg("rd_incr_rst", 32'h08, rdata);
    chk("incr_rst", 64'(rdata), 64'd8);
    rd_reg("rd_ctrl_rst", 32'h04, rdata);
    chk("ctrl_rst", 64'(rdata), 64'd0);
    rd_reg("rd_id", 32'h00, rdata);
    chk("id", 64'(rdata), 64'h7D0D_0001);

    wr_reg("wr_scratch", 32'h24, 32'hA5A5_5A5A);
    rd_reg("rd_scratch", 32'h24, rdata);
    chk("scratch", 64'(rdata), 64'hA5A5_5A5A);
    wr_reg("wr_nsload_ones", 32'h0C, 32'hFFFF_FFFF);
    rd_reg("rd_nsload_ones", 32'h0C, rdata);
    chk("nsload_unused", 64'(rdata), 64'h3FFF_FFFF);
    wr_reg("wr_sechi_ones", 32'h14, 32'hFFFF_FFFF);
    rd_reg("rd_sechi_ones", 32'h14, rdata);
    chk("sechi_unused", 64'(rdata), 64'h0000_FFFF);

    rd_reg("rd_unmapped", 32'h3C, rdata);
    chk("unmapped", 64'(rdata), 64'd0);
    rd_reg("rd_badbase", 32'h0000_0100, rdata);
    chk("badbase_rd", 64'(rdata), 64'd0);
    wr_reg("wr_badbase", 32'h0000_0124, 32'hDEAD_BEEF);
    rd_reg("rd_scratch2", 32'h24, rdata);
    chk("badbase_wr_dropped", 64'(rdata), 64'hA5A5_5A5A);
    rd_reg("rd_nssnap_rst", 32'h18, rdata);
    chk("nssnap_rst", 64'(rdata), 64'd0);

    // load just below a seconds boundary and watch the rollover
    wr_reg("wr_nsload", 32'h0C, 32'd999_999_992);
    wr_reg("wr_seclo", 32'h10, 32'hFFFF_FFFF);
    wr_reg("wr_sechi", 32'h14, 32'h0000_0000);
    set_req(1'b0, 1'b1, 32'h04, 32'h0000_0005);
    tick();
    clr_req();
    chk("load_ns", 64'(tod_ns), 64'd999_999_992);
    chk("load_sec", 64'(tod_sec), 64'h0000_FFFF_FFFF);
    chk("load_no_pps", 64'(pps), 64'd0);
    tick();
    chk("roll_ns", 64'(tod_ns), 64'd0);
    chk("roll_sec", 64'(tod_sec), 64'h0001_0000_0000);
    chk("roll_pps", 64'(pps), 64'd1);
    chk("load_complete", 64'(h_cpu_if.access_complete), 64'd1);
    tick();
    chk("after_roll_ns", 64'(tod_ns), 64'd8);
    chk("pps_one_cycle", 64'(pps), 64'd0);
    chk("load_pulse_end", 64'(h_cpu_if.access_complete), 64'd0);

    // snapshot taken now sees ns=8, sec=1_0000_0000
    wr_reg("wr_snap", 32'h04, 32'h0000_0003);
    rd_reg("rd_nssnap", 32'h18, rdata);
    chk("snap_ns", 64'(rdata), 64'd8);
    rd_reg("rd_secsnap_lo", 32'h1C, rdata);
    chk("snap_sec_lo", 64'(rdata), 64'd0);
    rd_reg("rd_secsnap_hi", 32'h20, rdata);
    chk("snap_sec_hi", 64'(rdata), 64'd1);
    rd_reg("rd_ctrl_pulses", 32'h04, rdata);
    chk("ctrl_pulse_bits", 64'(rdata), 64'd1);

    // over-range load clamps, and a disabled counter holds
    wr_reg("wr_nsload_big", 32'h0C, 32'h3FFF_FFFF);
    wr_reg("wr_load_dis", 32'h04, 32'h0000_0004);
    chk("clamp_ns", 64'(tod_ns), 64'd999_999_999);
    chk("clamp_sec", 64'(tod_sec), 64'h0000_FFFF_FFFF);
    repeat (3) tick();
    chk("hold_ns", 64'(tod_ns), 64'd999_999_999);
    chk("hold_pps", 64'(pps), 64'd0);

    wr_reg("wr_incr0", 32'h08, 32'd0);
    wr_reg("wr_en", 32'h04, 32'h0000_0001);
    repeat (4) tick();
    chk("incr0_ns", 64'(tod_ns), 64'd999_999_999);
    chk("incr0_sec", 64'(tod_sec), 64'h0000_FFFF_FFFF);

    // read+write together is a write and leaves read_data alone
    rd_reg("rd_id2", 32'h00, rdata);
    chk("id2", 64'(rdata), 64'h7D0D_0001);
    access("rdwr", 1'b1, 1'b1, 32'h24, 32'h1234_5678, rdata);
    chk("rdwr_read_data_held", 64'(rdata), 64'h7D0D_0001);
    rd_reg("rd_scratch3", 32'h24, rdata);
    chk("rdwr_wrote", 64'(rdata), 64'h1234_5678);

    // reset during WAIT aborts the access
    set_req(1'b1, 1'b0, 32'h00, 32'd0);
    tick();
    clr_req();
    h_reset_n = 1'b0;
    #1;
    chk("abort_read_data", 64'(h_cpu_if.read_data), 64'd0);
    chk("abort_tod_ns", 64'(tod_ns), 64'd0);
    chk("abort_tod_sec", 64'(tod_sec), 64'd0);
    chk("abort_pps", 64'(pps), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_complete", 64'(h_cpu_if.access_complete), 64'd0);
    end
    h_reset_n = 1'b1;
    tick();
    chk("post_abort_complete", 64'(h_cpu_if.access_complete), 64'd0);
    rd_reg("rd_incr_rst2", 32'h08, rdata);
    chk("incr_rst2", 64'(rdata), 64'd8);
    rd_reg("rd_ctrl_rst2", 32'h04, rdata);
    chk("ctrl_rst2", 64'(rdata), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
